// File: rtl/fpu_half_sched_if.sv
// Handshake and FPU-side bus of the two-requester half-precision FPU scheduler.
// slave: the scheduler itself; master: requesters plus FPU environment.
interface fpu_half_sched_if;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][2:0]  req_op;
    logic [1:0][15:0] req_a;
    logic [1:0][15:0] req_b;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [15:0]      rsp_data;
    logic [4:0]       rsp_flags;
    logic             fpu_start;
    logic [2:0]       fpu_op;
    logic [15:0]      fpu_a;
    logic [15:0]      fpu_b;
    logic             fpu_done;
    logic [15:0]      fpu_result;
    logic [4:0]       fpu_flags;
    logic             busy;
    logic             grant_id;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        input  fpu_done, fpu_result, fpu_flags,
        output req_ready, rsp_valid, rsp_data, rsp_flags,
        output fpu_start, fpu_op, fpu_a, fpu_b, busy, grant_id
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        output fpu_done, fpu_result, fpu_flags,
        input  req_ready, rsp_valid, rsp_data, rsp_flags,
        input  fpu_start, fpu_op, fpu_a, fpu_b, busy, grant_id
    );
endinterface

// File: rtl/fpu_half_sched.sv
// Round-robin scheduler sharing one half-precision FPU between two requesters.
// Define FPU_SCHED_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES cycles.
module fpu_half_sched #(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clock,
    input  logic            resetb,
    fpu_half_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             grant_q, grant_d;
    logic             fpu_start_q, fpu_start_d;
    logic [2:0]       fpu_op_q, fpu_op_d;
    logic [15:0]      fpu_a_q, fpu_a_d;
    logic [15:0]      fpu_b_q, fpu_b_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [15:0]      rsp_data_q, rsp_data_d;
    logic [4:0]       rsp_flags_q, rsp_flags_d;
    logic             busy_q, busy_d;

    logic             sel;
    logic [N_REQ-1:0] ready_w;
    logic             accept;

`ifdef FPU_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    if (N_REQ != 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("fpu_half_sched: N_REQ must be 2 and TIMEOUT_CYCLES at least 1");
    end

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        sel = bus.req_valid[1];
        if (bus.req_valid == 2'b11) begin
            sel = ~last_q;
        end
    end

    genvar gi;
    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
        assign ready_w[gi] = resetb && (state_q == IDLE) && bus.req_valid[gi]
                             && (sel == 1'(gi));
    end

    assign accept = |ready_w;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        fpu_start_d = 1'b0;
        fpu_op_d    = fpu_op_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
`ifdef FPU_SCHED_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    fpu_op_d    = bus.req_op[sel];
                    fpu_a_d     = bus.req_a[sel];
                    fpu_b_d     = bus.req_b[sel];
                    grant_d     = sel;
                    last_d      = sel;
                    fpu_start_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef FPU_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (bus.fpu_done) begin
                    rsp_data_d  = bus.fpu_result;
                    rsp_flags_d = bus.fpu_flags;
                    rsp_valid_d = grant_q ? 2'b10 : 2'b01;
                    state_d     = RESP;
                end
`ifdef FPU_SCHED_TIMEOUT_EN
                // Watchdog answers with a quiet NaN and the invalid flag.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_data_d  = 16'h7E00;
                    rsp_flags_d = 5'b10000;
                    rsp_valid_d = grant_q ? 2'b10 : 2'b01;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (bus.rsp_ready[grant_q]) begin
                    rsp_valid_d = 2'b00;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            grant_q     <= 1'b0;
            fpu_start_q <= 1'b0;
            fpu_op_q    <= 3'd0;
            fpu_a_q     <= 16'd0;
            fpu_b_q     <= 16'd0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= 16'd0;
            rsp_flags_q <= 5'd0;
            busy_q      <= 1'b0;
`ifdef FPU_SCHED_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            fpu_start_q <= fpu_start_d;
            fpu_op_q    <= fpu_op_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            busy_q      <= busy_d;
`ifdef FPU_SCHED_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.req_ready = ready_w;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.fpu_start = fpu_start_q;
    assign bus.fpu_op    = fpu_op_q;
    assign bus.fpu_a     = fpu_a_q;
    assign bus.fpu_b     = fpu_b_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = grant_q;
endmodule

// File: doc/fpu_half_sched.md
FPU_HALF_SCHED -- requirements
Module: fpu_half_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 2, meaning the number of requesters (fixed at 2; no other value is supported).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the WAIT-state watchdog limit when FPU_SCHED_TIMEOUT_EN is defined.
REQ-003 SHALL have port clock, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port resetb, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 2, per-requester operation request (bit i = requester i).
REQ-006 SHALL have port req_ready, output, 2, per-requester acceptance.
REQ-007 SHALL have port req_op, input, 2x3, per-requester FPU opcode.
REQ-008 SHALL have ports req_a and req_b, input, 2x16, per-requester half-precision operands.
REQ-009 SHALL have port rsp_valid, output, 2, per-requester result valid.
REQ-010 SHALL have port rsp_ready, input, 2, per-requester result acceptance.
REQ-011 SHALL have port rsp_data, output, 16, result shared by both requesters and qualified by rsp_valid.
REQ-012 SHALL have port rsp_flags, output, 5, IEEE exception flags {NV,DZ,OF,UF,NX}.
REQ-013 SHALL have port fpu_start, output, 1, one-cycle launch pulse to the FPU.
REQ-014 SHALL have ports fpu_op, fpu_a and fpu_b, output, 3/16/16, latched operation sent to the FPU.
REQ-015 SHALL have port fpu_done, input, 1, FPU completion pulse.
REQ-016 SHALL have ports fpu_result and fpu_flags, input, 16/5, FPU outputs, valid when fpu_done is high.
REQ-017 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-018 SHALL have port grant_id, output, 1, index of the requester currently owning the FPU.

Function
REQ-019 SHALL implement the states IDLE, ISSUE, WAIT and RESP.
REQ-020 In IDLE, req_ready[i] SHALL be high combinationally only for the selected requester i, and only when req_valid[i] is high.
- Selection: if one requester is valid, that requester is selected.
- If both are valid, the requester not granted last is selected (round-robin).
REQ-021 On acceptance (IDLE, req_valid[i] and req_ready[i]), the block SHALL:
- latch op/a/b into fpu_op/fpu_a/fpu_b;
- set grant_id to i and update the last-grant pointer;
- move to ISSUE.
REQ-022 ISSUE SHALL last exactly 1 cycle with fpu_start high, then move to WAIT; fpu_start SHALL be low in every other state.
REQ-023 In WAIT, on fpu_done the block SHALL latch fpu_result/fpu_flags into rsp_data/rsp_flags and move to RESP.
REQ-024 fpu_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-025 In RESP, rsp_valid[grant_id] SHALL be high and held, with data stable, until rsp_ready[grant_id] is high; the block then returns to IDLE on the next cycle.
REQ-026 Minimum latency SHALL be accept at cycle N, fpu_start at N+1, fpu_done at N+2 at the earliest, rsp_valid at N+3.
REQ-027 No new request SHALL be accepted outside IDLE; req_ready SHALL be 0 in ISSUE, WAIT and RESP.
REQ-028 A requester dropping req_valid before acceptance SHALL cancel its request with no side effects.
REQ-029 fpu_op/fpu_a/fpu_b SHALL remain stable from ISSUE through RESP.

Reset
REQ-030 While resetb is low, the block SHALL be in IDLE with all outputs at 0 (req_ready, rsp_valid, rsp_data, rsp_flags, fpu_*, busy, grant_id), and the last-grant pointer SHALL be 1 so that requester 0 wins the first tie.
REQ-031 Reset asserted mid-operation SHALL abort immediately; a later fpu_done from the aborted operation SHALL be ignored because the block is in IDLE.

Configuration
REQ-032 With FPU_SCHED_TIMEOUT_EN defined, a counter SHALL count the cycles spent in WAIT.
- When the count reaches TIMEOUT_CYCLES without fpu_done, the block SHALL enter RESP with rsp_data=16'h7E00 and rsp_flags=5'b10000.
- The counter SHALL clear on entering WAIT.
REQ-033 Without FPU_SCHED_TIMEOUT_EN, no counter SHALL exist and WAIT SHALL persist until fpu_done.

Verification
REQ-034 The bench SHALL cover:
- Single request: req0 op=0, a=16'h3C00, b=16'h4000; FPU model returns 16'h4200 one cycle after fpu_start -> rsp_valid[0] with rsp_data=16'h4200 at cycle N+3.
- Simultaneous: both req_valid high, repeatedly -> grants in order 0,1,0,1; four operations complete with no request lost.
- Backpressure: rsp_ready[1] held low for 10 cycles -> rsp_valid[1] and rsp_data stay stable and req_ready stays 0 for those 10 cycles.
- Spurious done: fpu_done pulsed in IDLE and in ISSUE -> no state change, no rsp_valid.
- Reset in WAIT: resetb low for 2 cycles, then fpu_done -> all outputs 0 and no response issued.
- With FPU_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=8, fpu_done never asserted -> rsp_data=16'h7E00 and rsp_flags=5'b10000, 8 cycles after entering WAIT.
